// File: rtl/hazard_stall_ctrl_pkg.sv
// rtl/hazard_stall_ctrl_pkg.sv - shared constants and types for the decode hazard stall controller
package hazard_stall_ctrl_pkg;

    localparam int REG_NUM   = 32;
    localparam int REG_IDX_W = 5;
    localparam int TIMEOUT_W = 8;

    typedef enum logic [1:0] {
        HS_RUN      = 2'd0,
        HS_LOAD_USE = 2'd1,
        HS_WAIT_SB  = 2'd2
    } hs_state_e;

    localparam logic STALL    = 1'b1;
    localparam logic NO_STALL = 1'b0;

    localparam logic                 W_REG_EN       = 1'b1;
    localparam logic                 FLUSH_PIPELINE = 1'b1;
    localparam logic [REG_IDX_W-1:0] ZERO           = '0;

    // A source only matters for forwarding/hazards if the instruction actually reads it
    function automatic logic src_match(
        input logic                 used,
        input logic [REG_IDX_W-1:0] src_idx,
        input logic [REG_IDX_W-1:0] dst_idx
    );
        return used && (src_idx == dst_idx);
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_reg_scoreboard.sv
// rtl/hazard_stall_ctrl_reg_scoreboard.sv - pending-write bit vector with two read ports
module hazard_stall_ctrl_reg_scoreboard #(
    parameter int REG_NUM   = 32,
    parameter int REG_IDX_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 set_en,
    input  logic [REG_IDX_W-1:0] set_idx,
    input  logic                 clr_en,
    input  logic [REG_IDX_W-1:0] clr_idx,
    input  logic [REG_IDX_W-1:0] rd_idx_a,
    input  logic [REG_IDX_W-1:0] rd_idx_b,
    output logic                 pend_a,
    output logic                 pend_b,
    output logic [REG_NUM-1:0]   pend_mask
);

    logic [REG_NUM-1:0] pend_q;
    logic [REG_NUM-1:0] pend_next;

    // Clear first, then set, so a new producer issued in the same cycle as the old one retires keeps the bit; x0 never pends
    always_comb begin
        pend_next = pend_q;
        for (int k = 1; k < REG_NUM; k++) begin
            if (clr_en && (clr_idx == REG_IDX_W'(k))) begin
                pend_next[k] = 1'b0;
            end
            if (set_en && (set_idx == REG_IDX_W'(k))) begin
                pend_next[k] = 1'b1;
            end
        end
        pend_next[0] = 1'b0;
    end

    // Scoreboard storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_next;
        end
    end

    // Read ports see only registered contents, no same-cycle bypass
    assign pend_a    = pend_q[rd_idx_a];
    assign pend_b    = pend_q[rd_idx_b];
    assign pend_mask = pend_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - decode-stage stall sequencer for load-use and multi-cycle destination hazards
module hazard_stall_ctrl #(
    parameter int REG_NUM   = 32,
    parameter int REG_IDX_W = 5,
    parameter int TIMEOUT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] rs1_dc,
    input  logic [REG_IDX_W-1:0] rs2_dc,
    input  logic                 rs1_used_dc,
    input  logic                 rs2_used_dc,
    input  logic                 valid_dc,
    input  logic [REG_IDX_W-1:0] rd_ex,
    input  logic                 wreg_en_ex,
    input  logic                 is_load_ex,
    input  logic                 valid_ex,
    input  logic                 issue_long,
    input  logic [REG_IDX_W-1:0] issue_rd,
    input  logic                 done_long,
    input  logic [REG_IDX_W-1:0] done_rd,
    input  logic                 flush,
    output logic                 stall_if,
    output logic                 stall_dc,
    output logic                 bubble_ex,
    output logic [REG_NUM-1:0]   pending_mask,
    output logic                 hazard_timeout
);

    import hazard_stall_ctrl_pkg::*;

    localparam logic [TIMEOUT_W-1:0] WD_MAX = '1;

    hs_state_e            state;
    logic                 pend_rs1;
    logic                 pend_rs2;
    logic                 lu_hit;
    logic                 sb_hit;
    logic                 stall;
    logic [TIMEOUT_W-1:0] wd_cnt;
    logic                 timeout_q;

    hazard_stall_ctrl_reg_scoreboard #(
        .REG_NUM   (REG_NUM),
        .REG_IDX_W (REG_IDX_W)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .set_en    (issue_long),
        .set_idx   (issue_rd),
        .clr_en    (done_long),
        .clr_idx   (done_rd),
        .rd_idx_a  (rs1_dc),
        .rd_idx_b  (rs2_dc),
        .pend_a    (pend_rs1),
        .pend_b    (pend_rs2),
        .pend_mask (pending_mask)
    );

    assign sb_hit = valid_dc && ((rs1_used_dc && pend_rs1) || (rs2_used_dc && pend_rs2));

    assign lu_hit = valid_dc && valid_ex && (wreg_en_ex == W_REG_EN) && is_load_ex &&
                    (rd_ex != ZERO) &&
                    (src_match(rs1_used_dc, rs1_dc, rd_ex) || src_match(rs2_used_dc, rs2_dc, rd_ex));

    // A flush cancels the DC instruction, so there is nothing left to hold
    assign stall     = ((lu_hit || sb_hit) && (flush != FLUSH_PIPELINE)) ? STALL : NO_STALL;
    assign stall_if  = stall;
    assign stall_dc  = stall;
    assign bubble_ex = stall;

    // Hazard sequencing FSM: load-use costs one cycle, scoreboard waits last until the bit clears
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= HS_RUN;
        end else if (flush == FLUSH_PIPELINE) begin
            state <= HS_RUN;
        end else begin
            case (state)
                HS_RUN: begin
                    if (lu_hit)      state <= HS_LOAD_USE;
                    else if (sb_hit) state <= HS_WAIT_SB;
                    else             state <= HS_RUN;
                end
                HS_LOAD_USE: begin
                    if (sb_hit) state <= HS_WAIT_SB;
                    else        state <= HS_RUN;
                end
                HS_WAIT_SB: begin
                    if (sb_hit) state <= HS_WAIT_SB;
                    else        state <= HS_RUN;
                end
                default: state <= HS_RUN;
            endcase
        end
    end

    // Watchdog: consecutive stall cycles, saturating; timeout latches once the count reaches all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else if (stall == STALL) begin
            if (wd_cnt != WD_MAX) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (wd_cnt >= WD_MAX - 1'b1) begin
                timeout_q <= 1'b1;
            end
        end else begin
            wd_cnt <= '0;
        end
    end

    assign hazard_timeout = timeout_q;

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Sequences decode-stage stalls for hazards that bypassing cannot resolve:
  - load-use on the EX result;
  - destinations still pending from multi-cycle units (load/store unit, divider).
- Holds a per-register pending-write scoreboard and a small FSM.
- Drives IF/DC stall and EX bubble-insert. Sits beside the decode-stage bypass network and consumes the same DC/EX indices.

Parameters:
- REG_NUM, 32, number of architectural integer registers.
- REG_IDX_W, 5, register index width.
- TIMEOUT_W, 8, width of the stall watchdog counter; timeout fires at all-ones.

Ports:
- clk  in  1  core clock.
- rst  in  1  reset; asynchronous, active-high.
- rs1_dc  in  REG_IDX_W  DC source 1 index.
- rs2_dc  in  REG_IDX_W  DC source 2 index.
- rs1_used_dc  in  1  DC instr reads rs1 (includes jalr).
- rs2_used_dc  in  1  DC instr reads rs2 (includes store data).
- valid_dc  in  1  DC holds a live, non-cancelled instruction.
- rd_ex  in  REG_IDX_W  EX destination.
- wreg_en_ex  in  1  EX instr writes rd.
- is_load_ex  in  1  EX instr is a load.
- valid_ex  in  1  EX live (not flushed, not cancelled).
- issue_long  in  1  a multi-cycle op leaves EX this cycle (load to memory, or divide).
- issue_rd  in  REG_IDX_W  destination of that op.
- done_long  in  1  a multi-cycle result is written back this cycle.
- done_rd  in  REG_IDX_W  destination of completed op.
- flush  in  1  pipeline flush (branch/trap redirect).
- stall_if  out  1  hold PC and IF/DC register.
- stall_dc  out  1  hold DC instruction.
- bubble_ex  out  1  insert NOP into EX next edge.
- pending_mask  out  REG_NUM  scoreboard contents; bit0 always 0.
- hazard_timeout  out  1  sticky: stall exceeded watchdog.

Behaviour:
- Reset: scoreboard=0, FSM=RUN, watchdog=0. Outputs stall_if, stall_dc, bubble_ex, hazard_timeout = 0; pending_mask=0.
- Scoreboard, per bit k:
  - set on issue_long && issue_rd==k && k!=0;
  - clear on done_long && done_rd==k.
  - Same-cycle set and clear on the same k: set wins (new producer).
  - Register 0 never set.
- sb_hit = valid_dc && ((rs1_used_dc && pend[rs1_dc]) || (rs2_used_dc && pend[rs2_dc])), using registered scoreboard contents (no same-cycle set/clear bypass).
- lu_hit = valid_dc && valid_ex && wreg_en_ex && is_load_ex && rd_ex!=0 && rd_ex matches a used source.
- FSM states RUN, LOAD_USE, WAIT_SB:
  - RUN: lu_hit -> LOAD_USE; else sb_hit -> WAIT_SB; else stay.
  - LOAD_USE: exactly one cycle. Then sb_hit -> WAIT_SB, else RUN.
  - WAIT_SB: stay while sb_hit; -> RUN the cycle sb_hit deasserts.
  - flush in any state -> RUN next edge. Scoreboard is NOT cleared by flush: issued ops still complete.
- Outputs are combinational from state plus current hits:
  - stall_if = stall_dc = bubble_ex = (lu_hit || sb_hit) && !flush.
  - In LOAD_USE the same equation applies; the load has moved on, so lu_hit is normally 0 there.
- Stall penalty: load-use = 1 cycle. Scoreboard wait ends the cycle after done_long clears the bit.
- Watchdog:
  - counts cycles with stall_dc=1; resets to 0 on any non-stall cycle.
  - at all-ones, hazard_timeout sets and stays set until rst; counter saturates.
- rst asserted mid-stall: all state cleared immediately (async), no stall next cycle.

Decomposition:
- Shared params header gains:
  - FSM state encodings HS_RUN / HS_LOAD_USE / HS_WAIT_SB;
  - STALL / NO_STALL constants;
  - REG_NUM.
  - Reuse existing W_REG_EN, ZERO and FLUSH_PIPELINE defines.
- One natural sub-module, reg_scoreboard: the set/clear bit vector plus the two read ports.

Test Plan:
- Load x5 in EX, DC add uses rs1=x5 -> stall_dc=1 for exactly 1 cycle, bubble_ex=1, FSM RUN->LOAD_USE->RUN.
- issue_long rd=x7; DC uses rs2=x7 for 4 cycles; done_long rd=x7 at cycle 4 -> stall held cycles 1-4, released cycle 5; pending_mask[7] 1->0.
- Same cycle issue_long rd=x3 and done_long rd=x3 -> pending_mask[3]=1 afterwards.
- issue_long rd=x0, DC uses x0; load in EX with rd=x0 -> no stall, pending_mask=0.
- In WAIT_SB on x9, assert flush -> stalls drop that cycle, FSM=RUN next, pending_mask[9] still 1 until done_long.
- Hold sb_hit 255 cycles (TIMEOUT_W=8) -> hazard_timeout=1 and stays 1 after release; rst clears it.
